// File: rtl/result_checker_pkg.sv
// Shared widths, expected/error word layout and checker state encoding.
// Also used by the DUT interface to size RES_FIFO / EXP_FIFO / ERR_FIFO.
package result_checker_pkg;

   localparam int RC_RTF_WIDTH = 24;
   localparam int RC_IDX_WIDTH = 16;
   localparam int RC_ERR_WIDTH = 16;

   // Expected word layout: {last, mask, expected}
   localparam int EXP_DATA_LSB = 0;

   function automatic int exp_mask_lsb(input int rtf_w);
      return rtf_w;
   endfunction

   function automatic int exp_last_bit(input int rtf_w);
      return 2 * rtf_w;
   endfunction

   function automatic int exp_width(input int rtf_w);
      return 2 * rtf_w + 1;
   endfunction

   // Error record layout: {vec_index, masked diff}
   function automatic int erf_width(input int idx_w, input int rtf_w);
      return idx_w + rtf_w;
   endfunction

   localparam int RC_ERF_WIDTH = erf_width(RC_IDX_WIDTH, RC_RTF_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } rc_state_e;

endpackage

// File: rtl/result_err_skid.sv
// One-entry holding register for an error record that met a full error FIFO.
// Passes records straight through when the FIFO has room.
module result_err_skid
   import result_checker_pkg::*;
#(
   parameter int ERF_WIDTH = RC_ERF_WIDTH
) (
   input  logic                 clock_gated,
   input  logic                 reset_n,
   input  logic                 clear_i,
   input  logic                 rec_valid_i,
   input  logic [ERF_WIDTH-1:0] rec_data_i,
   input  logic                 wrfull_i,
   output logic                 wrreq_o,
   output logic [ERF_WIDTH-1:0] data_o,
   output logic                 pend_o,
   output logic                 drain_o
);

   logic                 pend_q, pend_d;
   logic [ERF_WIDTH-1:0] rec_q, rec_d;

   always_comb begin
      pend_d  = pend_q;
      rec_d   = rec_q;
      wrreq_o = 1'b0;
      drain_o = 1'b0;
      data_o  = '0;
      if (clear_i) begin
         pend_d = 1'b0;
      end else if (pend_q) begin
         data_o = rec_q;
         if (!wrfull_i) begin
            wrreq_o = 1'b1;
            drain_o = 1'b1;
            pend_d  = 1'b0;
         end
      end else if (rec_valid_i) begin
         data_o = rec_data_i;
         if (wrfull_i) begin
            pend_d = 1'b1;
            rec_d  = rec_data_i;
         end else begin
            wrreq_o = 1'b1;
         end
      end
   end

   always_ff @(posedge clock_gated or negedge reset_n) begin
      if (!reset_n) pend_q <= 1'b0;
      else          pend_q <= pend_d;
   end

   // Record payload is only observed while pend_q is set, so it needs no reset.
   always_ff @(posedge clock_gated) begin
      rec_q <= rec_d;
   end

   assign pend_o = pend_q;

endmodule

// File: rtl/result_checker.sv
// Pops DUT results and masked expected words in lockstep, compares them,
// counts vectors/mismatches and emits one error record per failing vector.
module result_checker
   import result_checker_pkg::*;
#(
   parameter int RTF_WIDTH = RC_RTF_WIDTH,
   parameter int IDX_WIDTH = RC_IDX_WIDTH,
   parameter int ERR_WIDTH = RC_ERR_WIDTH,
   parameter int EXP_WIDTH = exp_width(RTF_WIDTH),
   parameter int ERF_WIDTH = erf_width(IDX_WIDTH, RTF_WIDTH)
) (
   input  logic                 clock_gated,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [RTF_WIDTH-1:0] rfifo_q,
   input  logic                 rfifo_rdempty,
   output logic                 rfifo_rdreq,
   input  logic [EXP_WIDTH-1:0] efifo_q,
   input  logic                 efifo_rdempty,
   output logic                 efifo_rdreq,
   output logic [ERF_WIDTH-1:0] errfifo_data,
   output logic                 errfifo_wrreq,
   input  logic                 errfifo_wrfull,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [IDX_WIDTH-1:0] vec_count,
   output logic [ERR_WIDTH-1:0] err_count,
   output logic [IDX_WIDTH-1:0] first_fail
);

   localparam int MASK_LSB = exp_mask_lsb(RTF_WIDTH);
   localparam int LAST_BIT = exp_last_bit(RTF_WIDTH);

   function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   rc_state_e            state_q, state_d;
   logic                 v1_q;
   logic                 last_seen_q, last_seen_d;
   logic [IDX_WIDTH-1:0] vec_count_q, vec_count_d;
   logic [IDX_WIDTH-1:0] first_fail_q, first_fail_d;
   logic [ERR_WIDTH-1:0] err_count_q, err_count_d;

   logic [RTF_WIDTH-1:0] exp_word, exp_mask, diff;
   logic                 exp_last, mismatch, rdreq, rec_valid;
   logic                 err_pend, pend_drain;

   assign exp_word = efifo_q[EXP_DATA_LSB +: RTF_WIDTH];
   assign exp_mask = efifo_q[MASK_LSB +: RTF_WIDTH];
   assign exp_last = efifo_q[LAST_BIT];
   assign diff     = (rfifo_q ^ exp_word) & exp_mask;
   assign mismatch = |diff;

   // Stop popping while a record cannot be placed, and after a last vector.
   assign rdreq = (state_q == ST_RUN) && !rfifo_rdempty && !efifo_rdempty && !err_pend
                  && !(v1_q && mismatch && errfifo_wrfull) && !(v1_q && exp_last) && !start;
   assign rec_valid = v1_q && mismatch && !start;

   result_err_skid #(.ERF_WIDTH(ERF_WIDTH)) u_skid (
      .clock_gated (clock_gated),
      .reset_n     (reset_n),
      .clear_i     (start),
      .rec_valid_i (rec_valid),
      .rec_data_i  ({vec_count_q, diff}),
      .wrfull_i    (errfifo_wrfull),
      .wrreq_o     (errfifo_wrreq),
      .data_o      (errfifo_data),
      .pend_o      (err_pend),
      .drain_o     (pend_drain)
   );

   always_comb begin
      state_d      = state_q;
      last_seen_d  = last_seen_q;
      vec_count_d  = vec_count_q;
      err_count_d  = err_count_q;
      first_fail_d = first_fail_q;
      if (start) begin
         state_d      = ST_RUN;
         last_seen_d  = 1'b0;
         vec_count_d  = '0;
         err_count_d  = '0;
         first_fail_d = '1;
      end else begin
         if (v1_q) begin
            vec_count_d = vec_count_q + 1'b1;
            if (mismatch) begin
               err_count_d = sat_inc(err_count_q);
               if (&first_fail_q) first_fail_d = vec_count_q;
            end
            // A last vector whose record got parked finishes once it drains.
            if (exp_last) begin
               if (mismatch && errfifo_wrfull) last_seen_d = 1'b1;
               else                            state_d     = ST_DONE;
            end
         end
         if (last_seen_q && pend_drain) begin
            state_d     = ST_DONE;
            last_seen_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clock_gated or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         v1_q         <= 1'b0;
         last_seen_q  <= 1'b0;
         vec_count_q  <= '0;
         err_count_q  <= '0;
         first_fail_q <= '1;
      end else begin
         state_q      <= state_d;
         v1_q         <= rdreq;
         last_seen_q  <= last_seen_d;
         vec_count_q  <= vec_count_d;
         err_count_q  <= err_count_d;
         first_fail_q <= first_fail_d;
      end
   end

   assign rfifo_rdreq = rdreq;
   assign efifo_rdreq = rdreq;
   assign busy        = (state_q == ST_RUN);
   assign done        = (state_q == ST_DONE);
   assign pass        = done && (err_count_q == '0);
   assign vec_count   = vec_count_q;
   assign err_count   = err_count_q;
   assign first_fail  = first_fail_q;

endmodule
